// File: rtl/reg_asm_pkg.sv
// reg_asm_pkg: shared types and helpers for reg_byte_assembler.
// Optional feature macro: REG_ASM_TIMEOUT_EN (see reg_byte_assembler.sv).
package reg_asm_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} reg_asm_state_e;

  // ceil(nbits/8) clamped to max; 9-bit sum so 255+7 does not wrap
  function automatic logic [5:0] num_bytes(input logic [7:0] nbits, input int unsigned max);
    logic [5:0] n;
    n = 6'((9'(nbits) + 9'd7) >> 3);
    if (32'(n) > max) n = 6'(max);
    return n;
  endfunction

  // Mask for the final byte: keeps bits below nbits, full byte on a multiple of 8
  function automatic logic [7:0] last_byte_mask(input logic [7:0] nbits);
    logic [7:0] m;
    if (nbits[2:0] == 3'd0) m = 8'hFF;
    else                    m = 8'((9'd1 << nbits[2:0]) - 9'd1);
    return m;
  endfunction

endpackage

// File: rtl/reg_byte_assembler_idle_timer.sv
// idle_timer: counts idle cycles while enabled; any clear or disable restarts it.
// Used by reg_byte_assembler only when REG_ASM_TIMEOUT_EN is defined.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic EN_I,
  input  logic CLR_I,
  output logic EXPIRED_O
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  // Saturating idle counter, restarted by a clear or when not enabled
  always_ff @(posedge CLK_I) begin
    if (RST_I || !EN_I || CLR_I) cnt_q <= '0;
    else if (cnt_q != LAST)      cnt_q <= cnt_q + TW'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle
  assign EXPIRED_O = EN_I && !CLR_I && (cnt_q == LAST);

endmodule

// File: rtl/reg_byte_assembler.sv
// reg_byte_assembler: assembles an RX byte stream LSB-byte-first into a register
// of NUM_BITS_I bits and hands it over with a valid/ready handshake.
// Optional feature macro: REG_ASM_TIMEOUT_EN -- aborts a transfer after
// TIMEOUT_CYCLES idle cycles in COLLECT and pulses TIMEOUT_O.
module reg_byte_assembler
  import reg_asm_pkg::*;
#(
  parameter int MAX_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [7:0]             NUM_BITS_I,
  input  logic                   START_I,
  input  logic [7:0]             BYTE_I,
  input  logic                   BYTE_VALID_I,
  output logic                   BYTE_READY_O,
  output logic [8*MAX_BYTES-1:0] REG_O,
  output logic                   REG_VALID_O,
  input  logic                   REG_READY_I,
  output logic                   BUSY_O,
  output logic                   TIMEOUT_O
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  if (MAX_BYTES < 1 || MAX_BYTES > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("reg_byte_assembler: MAX_BYTES must be 1..32 and TIMEOUT_CYCLES >= 2");
  end

  reg_asm_state_e                  state_q;
  logic [CW-1:0]                   cnt_q, nbytes_q, start_nb;
  logic [7:0]                      mask_q, start_mask;
  logic [MAX_BYTES-1:0][7:0]       reg_q;
  logic                            valid_q, tmo_q;
  logic                            accept, last, expired;

  // Byte count for the new transfer and the mask for its final byte. When
  // NUM_BITS_I exceeds the register, the clamped last byte is entirely in range.
  assign start_nb   = CW'(num_bytes(NUM_BITS_I, MAX_BYTES));
  assign start_mask = (9'(NUM_BITS_I) >= 9'(8 * MAX_BYTES)) ? 8'hFF : last_byte_mask(NUM_BITS_I);

  assign accept = (state_q == COLLECT) && BYTE_VALID_I;
  assign last   = (cnt_q == nbytes_q - CW'(1));

`ifdef REG_ASM_TIMEOUT_EN
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .EN_I      (state_q == COLLECT),
    .CLR_I     (accept),
    .EXPIRED_O (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Transfer FSM: latch length on start, fill bytes, hold until consumed
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nbytes_q <= '0;
      mask_q   <= '0;
      reg_q    <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: if (START_I) begin
          nbytes_q <= start_nb;
          mask_q   <= start_mask;
          cnt_q    <= '0;
          reg_q    <= '0;
          if (start_nb == '0) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end else begin
            state_q <= COLLECT;
          end
        end
        COLLECT: if (accept) begin
          reg_q[cnt_q[IW-1:0]] <= last ? (BYTE_I & mask_q) : BYTE_I;
          cnt_q                <= cnt_q + CW'(1);
          if (last) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end else if (expired) begin
          state_q <= IDLE;
          reg_q   <= '0;
          cnt_q   <= '0;
          tmo_q   <= 1'b1;
        end
        HOLD: if (REG_READY_I) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BYTE_READY_O = (state_q == COLLECT);
  assign BUSY_O       = (state_q != IDLE);
  assign REG_O        = reg_q;
  assign REG_VALID_O  = valid_q;
  assign TIMEOUT_O    = tmo_q;

endmodule

// File: tb/tb_reg_byte_assembler.sv
// Bench for reg_byte_assembler: directed transfers, a queue-based reference
// model checked every cycle, and literal expectations for each scenario.
// The timeout scenario is compiled in only with REG_ASM_TIMEOUT_EN.
module tb_reg_byte_assembler;
  localparam int MAXB = 4;
  localparam int TMO  = 16;
  localparam int RW   = 8 * MAXB;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b1;
  logic [7:0]    NUM_BITS_I = '0;
  logic          START_I = 1'b0;
  logic [7:0]    BYTE_I = '0;
  logic          BYTE_VALID_I = 1'b0;
  logic          BYTE_READY_O;
  logic [RW-1:0] REG_O;
  logic          REG_VALID_O;
  logic          REG_READY_I = 1'b0;
  logic          BUSY_O;
  logic          TIMEOUT_O;

  reg_byte_assembler #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .NUM_BITS_I(NUM_BITS_I), .START_I(START_I),
    .BYTE_I(BYTE_I), .BYTE_VALID_I(BYTE_VALID_I), .BYTE_READY_O(BYTE_READY_O),
    .REG_O(REG_O), .REG_VALID_O(REG_VALID_O), .REG_READY_I(REG_READY_I),
    .BUSY_O(BUSY_O), .TIMEOUT_O(TIMEOUT_O)
  );

  always #5 CLK_I = ~CLK_I;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase 0 = waiting for start, 1 = taking bytes, 2 = register offered
  int         m_phase = 0;
  logic [7:0] m_q[$];
  int         m_nb = 0, m_nbits = 0, m_idle = 0;
  logic [RW-1:0] m_reg = '0;
  bit         m_tmo = 0;
  bit         model_live = 0;

  // Register = received bytes stacked LSB-first, truncated to the requested bit count
  function automatic logic [RW-1:0] assemble();
    logic [63:0] r = '0;
    foreach (m_q[k]) r |= 64'(m_q[k]) << (8 * k);
    if (m_nbits < RW) r &= (64'd1 << m_nbits) - 64'd1;
    return r[RW-1:0];
  endfunction

  always @(posedge CLK_I) begin
    m_tmo = 0;
    if (RST_I) begin
      m_phase = 0; m_q.delete(); m_reg = '0; m_idle = 0;
      model_live = 1;
    end else begin
      case (m_phase)
        0: if (START_I) begin
          m_nbits = int'(NUM_BITS_I);
          m_nb    = (m_nbits + 7) / 8;
          if (m_nb > MAXB) m_nb = MAXB;
          m_q.delete(); m_reg = '0; m_idle = 0;
          m_phase = (m_nb == 0) ? 2 : 1;
        end
        1: if (BYTE_VALID_I) begin
          m_q.push_back(BYTE_I);
          m_reg  = assemble();
          m_idle = 0;
          if (m_q.size() == m_nb) m_phase = 2;
        end else begin
          m_idle++;
`ifdef REG_ASM_TIMEOUT_EN
          if (m_idle == TMO) begin
            m_phase = 0; m_reg = '0; m_q.delete(); m_tmo = 1;
          end
`endif
        end
        default: if (REG_READY_I) m_phase = 0;
      endcase
    end
  end

  // Compare the DUT against the model every cycle once reset has been seen
  always @(posedge CLK_I) begin
    #2;
    if (model_live) begin
      chk("byte_ready", 64'(BYTE_READY_O), 64'(m_phase == 1));
      chk("reg_valid",  64'(REG_VALID_O),  64'(m_phase == 2));
      chk("busy",       64'(BUSY_O),       64'(m_phase != 0));
      chk("reg",        64'(REG_O),        64'(m_reg));
      chk("timeout",    64'(TIMEOUT_O),    64'(m_tmo));
    end
  end

  // Observers for the literal checks
  int hs = 0, tmo_pulses = 0;
  bit valid_seen = 0;
  always @(posedge CLK_I) if (!RST_I && BYTE_VALID_I && BYTE_READY_O) hs++;
  always @(negedge CLK_I) begin
    if (TIMEOUT_O === 1'b1) tmo_pulses++;
    if (REG_VALID_O === 1'b1) valid_seen = 1;
  end

  task automatic step(); @(negedge CLK_I); endtask

  task automatic consume();
    REG_READY_I = 1'b1; step(); REG_READY_I = 1'b0;
  endtask

  task automatic start(input logic [7:0] nbits);
    NUM_BITS_I = nbits; START_I = 1'b1; step(); START_I = 1'b0;
  endtask

  logic [7:0] b1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] b5 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    repeat (2) step();
    RST_I = 1'b0;
    chk("rst_reg",   64'(REG_O), 64'h0);
    chk("rst_valid", 64'(REG_VALID_O), 64'h0);
    chk("rst_ready", 64'(BYTE_READY_O), 64'h0);
    chk("rst_busy",  64'(BUSY_O), 64'h0);
    chk("rst_tmo",   64'(TIMEOUT_O), 64'h0);

    // 1: full 32-bit register, back-to-back bytes
    hs = 0;
    start(8'd32);
    for (int i = 0; i < 4; i++) begin
      BYTE_VALID_I = 1'b1; BYTE_I = b1[i];
      if (i == 3) chk("t1_valid_before_last", 64'(REG_VALID_O), 64'h0);
      step();
    end
    BYTE_VALID_I = 1'b0;
    chk("t1_latency", 64'(REG_VALID_O), 64'h1);
    chk("t1_reg", 64'(REG_O), 64'h44332211);
    chk("t1_hs", 64'(hs), 64'd4);
    consume();
    chk("t1_idle", 64'(BUSY_O), 64'h0);

    // 2: 12 bits, second byte masked; a mid-transfer START is ignored
    hs = 0;
    start(8'd12);
    BYTE_VALID_I = 1'b1; BYTE_I = 8'hFF; step();
    START_I = 1'b1; NUM_BITS_I = 8'd8; step();
    START_I = 1'b0; step();
    BYTE_VALID_I = 1'b0;
    chk("t2_reg", 64'(REG_O), 64'h00000FFF);
    chk("t2_hs", 64'(hs), 64'd2);
    chk("t2_ready_hold", 64'(BYTE_READY_O), 64'h0);
    consume();

    // 3: zero-length register, held while the consumer stalls
    start(8'd0);
    chk("t3_valid", 64'(REG_VALID_O), 64'h1);
    chk("t3_reg", 64'(REG_O), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 64'(REG_VALID_O), 64'h1);
      chk("t3_hold_reg", 64'(REG_O), 64'h0);
    end
    REG_READY_I = 1'b1; START_I = 1'b1; NUM_BITS_I = 8'd32; step();
    REG_READY_I = 1'b0; START_I = 1'b0;
    chk("t3_start_on_exit", 64'(BUSY_O), 64'h0);
    step();
    chk("t3_still_idle", 64'(BUSY_O), 64'h0);

    // 4: oversize length clamps to MAX_BYTES; fifth byte not taken
    hs = 0;
    start(8'd200);
    for (int i = 0; i < 5; i++) begin
      BYTE_VALID_I = 1'b1; BYTE_I = 8'(i + 1); step();
    end
    BYTE_VALID_I = 1'b0;
    chk("t4_hs", 64'(hs), 64'd4);
    chk("t4_reg", 64'(REG_O), 64'h04030201);
    consume();

    // 5: reset mid-transfer, then a 27-bit transfer completes
    start(8'd32);
    BYTE_VALID_I = 1'b1; BYTE_I = 8'hAA; step();
    BYTE_I = 8'hBB; step();
    RST_I = 1'b1; BYTE_I = 8'hCC; step();
    RST_I = 1'b0; BYTE_VALID_I = 1'b0;
    chk("t5_rst_reg", 64'(REG_O), 64'h0);
    chk("t5_rst_busy", 64'(BUSY_O), 64'h0);
    chk("t5_rst_ready", 64'(BYTE_READY_O), 64'h0);
    chk("t5_rst_valid", 64'(REG_VALID_O), 64'h0);
    start(8'd27);
    for (int i = 0; i < 4; i++) begin
      BYTE_VALID_I = 1'b1; BYTE_I = b5[i]; step();
    end
    BYTE_VALID_I = 1'b0;
    chk("t5_valid", 64'(REG_VALID_O), 64'h1);
    chk("t5_reg", 64'(REG_O), 64'h04C3B2A1);
    consume();

`ifdef REG_ASM_TIMEOUT_EN
    // 6: stall after one byte until the idle timer aborts
    start(8'd32);
    BYTE_VALID_I = 1'b1; BYTE_I = 8'h5A; step();
    BYTE_VALID_I = 1'b0;
    tmo_pulses = 0; valid_seen = 0;
    repeat (40) step();
    chk("t6_pulses", 64'(tmo_pulses), 64'd1);
    chk("t6_no_valid", 64'(valid_seen), 64'd0);
    chk("t6_idle", 64'(BUSY_O), 64'h0);
    chk("t6_reg", 64'(REG_O), 64'h0);
`else
    // Without the timeout feature a stalled transfer just waits
    start(8'd32);
    BYTE_VALID_I = 1'b1; BYTE_I = 8'h5A; step();
    BYTE_VALID_I = 1'b0;
    tmo_pulses = 0;
    repeat (40) step();
    chk("t6_no_pulse", 64'(tmo_pulses), 64'd0);
    chk("t6_still_busy", 64'(BUSY_O), 64'h1);
    chk("t6_partial_reg", 64'(REG_O), 64'h5A);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
